// File: rtl/kulisch_pkg.sv
// Shared parameters, state encoding and fp16 constants for the Kulisch fp16 accumulator.
package kulisch_pkg;

  localparam int unsigned EWIDTH   = 5;
  localparam int unsigned MWIDTH   = 10;
  localparam int unsigned BIAS     = 15;
  localparam int unsigned GUARD    = 8;
  localparam int unsigned DWIDTH   = 16;

  localparam int          EXP_MIN  = -28;
  localparam int          EXP_MAX  = 30;
  localparam int unsigned FRAC_LSB = 48;
  localparam int unsigned ACC_W    = 81 + GUARD;
  localparam int unsigned MANT_W   = 2 * MWIDTH + 2;
  localparam int unsigned POS_W    = $clog2(ACC_W);

  localparam logic [DWIDTH-1:0] FP16_QNAN = 16'h7E00;
  localparam logic [DWIDTH-1:0] FP16_INF  = 16'h7C00;

  typedef enum logic [1:0] {
    ACC   = 2'd0,
    DRAIN = 2'd1,
    NORM  = 2'd2,
    OUT   = 2'd3
  } state_t;

endpackage

// File: rtl/kulisch_fp16_round.sv
// Combinational leading-one detect, normalize and round-to-nearest-even of the
// two's complement Kulisch accumulator into an IEEE-754 binary16 value.
module kulisch_fp16_round
  import kulisch_pkg::*;
(
  input  logic [ACC_W-1:0]  i_acc,
  output logic [DWIDTH-1:0] o_result_c,
  output logic              o_overflow_c,
  output logic              o_underflow_c
);

  // Leading-one position of the smallest normal (2^-14), and LSB of the subnormal grid (2^-24).
  localparam int unsigned NORM_MIN_P = FRAC_LSB - (BIAS - 1);
  localparam int unsigned SUB_LSB    = NORM_MIN_P - MWIDTH;
  localparam int unsigned EXP_W      = POS_W + 1;
  localparam int unsigned EXP_INF    = (1 << EWIDTH) - 1;

  logic              w_sign;
  logic [ACC_W-1:0]  w_mag;
  logic [POS_W-1:0]  w_p;
  logic              w_nz;
  logic [ACC_W-2:0]  w_norm;
  logic [MWIDTH-1:0] w_n_frac;
  logic              w_n_guard;
  logic              w_n_sticky;
  logic [MWIDTH:0]   w_n_rnd;
  logic [EXP_W-1:0]  w_n_exp;
  logic [MWIDTH-1:0] w_s_frac;
  logic              w_s_guard;
  logic              w_s_sticky;
  logic [MWIDTH:0]   w_s_rnd;
  logic              w_is_norm;

  always_comb begin
    w_sign = i_acc[ACC_W-1];
    w_mag  = w_sign ? -i_acc : i_acc;
  end

  always_comb begin
    w_p  = '0;
    w_nz = 1'b0;
    for (int i = 0; i < ACC_W; i++) begin
      if (w_mag[i]) begin
        w_p  = POS_W'(i);
        w_nz = 1'b1;
      end
    end
  end

  // Normal path: hidden one shifted out of the top, fraction/guard/sticky below it.
  always_comb begin
    w_norm     = (ACC_W-1)'(w_mag << (POS_W'(ACC_W - 1) - w_p));
    w_n_frac   = w_norm[ACC_W-2 -: MWIDTH];
    w_n_guard  = w_norm[ACC_W-2-MWIDTH];
    w_n_sticky = |w_norm[ACC_W-3-MWIDTH:0];
    w_n_rnd    = {1'b0, w_n_frac}
               + (MWIDTH+1)'(w_n_guard & (w_n_sticky | w_n_frac[0]));
    w_n_exp    = EXP_W'(w_p) - EXP_W'(FRAC_LSB - BIAS) + EXP_W'(w_n_rnd[MWIDTH]);
    w_is_norm  = (w_p >= POS_W'(NORM_MIN_P));
  end

  // Subnormal path: fixed 2^-24 grid; a carry into bit MWIDTH lands on the smallest normal.
  always_comb begin
    w_s_frac   = w_mag[SUB_LSB+MWIDTH-1 : SUB_LSB];
    w_s_guard  = w_mag[SUB_LSB-1];
    w_s_sticky = |w_mag[SUB_LSB-2:0];
    w_s_rnd    = {1'b0, w_s_frac}
               + (MWIDTH+1)'(w_s_guard & (w_s_sticky | w_s_frac[0]));
  end

  always_comb begin
    o_result_c    = '0;
    o_overflow_c  = 1'b0;
    o_underflow_c = 1'b0;
    if (!w_nz) begin
      o_result_c = '0;
    end else if (w_is_norm) begin
      if (w_n_exp >= EXP_W'(EXP_INF)) begin
        o_result_c   = FP16_INF | {w_sign, (DWIDTH-1)'(0)};
        o_overflow_c = 1'b1;
      end else begin
        o_result_c = {w_sign, w_n_exp[EWIDTH-1:0], w_n_rnd[MWIDTH-1:0]};
      end
    end else if (w_s_rnd == '0) begin
      o_result_c    = {w_sign, (DWIDTH-1)'(0)};
      o_underflow_c = 1'b1;
    end else begin
      o_result_c = {w_sign, (DWIDTH-1)'(w_s_rnd)};
    end
  end

endmodule

// File: rtl/kulisch_acc_fp16.sv
// Exact Kulisch accumulation of redundant fp16 products; emits one rounded
// binary16 result per dot product under a valid/ready handshake.
module kulisch_acc_fp16
  import kulisch_pkg::*;
(
  input  logic              CLK,
  input  logic              RST,
  input  logic              i_valid,
  output logic              i_ready,
  input  logic [MANT_W-1:0] i_sum,
  input  logic [MANT_W-1:0] i_carry,
  input  logic [EWIDTH:0]   i_exponent,
  input  logic              i_sign,
  input  logic              i_exception,
  input  logic              i_last,
  output logic              o_valid,
  input  logic              o_ready,
  output logic [DWIDTH-1:0] o_result,
  output logic              o_overflow,
  output logic              o_underflow
);

  state_t            r_state;
  logic              r_in_ready;
  logic              r_out_valid;
  logic [DWIDTH-1:0] r_result;
  logic              r_ovf;
  logic              r_unf;
  logic              r_nan;
  logic              r_s1_vld;
  logic [ACC_W-1:0]  r_s1_op;
  logic [ACC_W-1:0]  r_acc;

  logic [MANT_W-1:0] w_mant;
  logic              w_exp_ok;
  logic              w_bad;
  logic [EWIDTH:0]   w_sh;
  logic [ACC_W-1:0]  w_aligned;
  logic [ACC_W-1:0]  w_op;
  logic              w_accept;
  logic              w_done;
  logic [DWIDTH-1:0] w_rnd_result;
  logic              w_rnd_ovf;
  logic              w_rnd_unf;

  // Resolve the redundant pair, align onto the 2^-48 grid and apply the sign.
  always_comb begin
    w_mant    = i_sum + i_carry;
    w_exp_ok  = (int'($signed(i_exponent)) >= EXP_MIN) &&
                (int'($signed(i_exponent)) <= EXP_MAX);
    w_bad     = i_exception | ~w_exp_ok;
    w_sh      = i_exponent + (EWIDTH+1)'(-EXP_MIN);
    w_aligned = ACC_W'(w_mant) << w_sh;
    w_op      = i_sign ? -w_aligned : w_aligned;
    w_accept  = i_valid & r_in_ready;
    w_done    = r_out_valid & o_ready;
  end

  kulisch_fp16_round u_round (
    .i_acc         (r_acc),
    .o_result_c    (w_rnd_result),
    .o_overflow_c  (w_rnd_ovf),
    .o_underflow_c (w_rnd_unf)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state     <= ACC;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_ovf       <= 1'b0;
      r_unf       <= 1'b0;
      r_nan       <= 1'b0;
      r_s1_vld    <= 1'b0;
      r_s1_op     <= '0;
      r_acc       <= '0;
    end else begin
      r_s1_vld <= w_accept;
      r_s1_op  <= (w_accept && !w_bad) ? w_op : '0;

      if (w_done) begin
        r_acc <= '0;
      end else if (r_s1_vld) begin
        r_acc <= r_acc + r_s1_op;
      end

      if (w_done) begin
        r_nan <= 1'b0;
      end else if (w_accept && w_bad) begin
        r_nan <= 1'b1;
      end

      case (r_state)
        ACC: begin
          if (w_accept && i_last) begin
            r_state    <= DRAIN;
            r_in_ready <= 1'b0;
          end
        end
        DRAIN: r_state <= NORM;
        NORM: begin
          r_state     <= OUT;
          r_out_valid <= 1'b1;
          if (r_nan) begin
            r_result <= FP16_QNAN;
            r_ovf    <= 1'b0;
            r_unf    <= 1'b0;
          end else begin
            r_result <= w_rnd_result;
            r_ovf    <= w_rnd_ovf;
            r_unf    <= w_rnd_unf;
          end
        end
        OUT: begin
          if (o_ready) begin
            r_state     <= ACC;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_ovf       <= 1'b0;
            r_unf       <= 1'b0;
          end
        end
        default: r_state <= ACC;
      endcase
    end
  end

  assign i_ready     = r_in_ready;
  assign o_valid     = r_out_valid;
  assign o_result    = r_result;
  assign o_overflow  = r_ovf;
  assign o_underflow = r_unf;

endmodule

// File: tb/tb_kulisch_acc_fp16.sv
// Directed self-checking bench for kulisch_acc_fp16 with hand-computed fp16 results.
module tb_kulisch_acc_fp16;

  logic        CLK;
  logic        RST;
  logic        i_valid;
  logic        i_ready;
  logic [21:0] i_sum;
  logic [21:0] i_carry;
  logic [5:0]  i_exponent;
  logic        i_sign;
  logic        i_exception;
  logic        i_last;
  logic        o_valid;
  logic        o_ready;
  logic [15:0] o_result;
  logic        o_overflow;
  logic        o_underflow;

  int n_checks = 0;
  int n_errors = 0;

  kulisch_acc_fp16 dut (
    .CLK         (CLK),
    .RST         (RST),
    .i_valid     (i_valid),
    .i_ready     (i_ready),
    .i_sum       (i_sum),
    .i_carry     (i_carry),
    .i_exponent  (i_exponent),
    .i_sign      (i_sign),
    .i_exception (i_exception),
    .i_last      (i_last),
    .o_valid     (o_valid),
    .o_ready     (o_ready),
    .o_result    (o_result),
    .o_overflow  (o_overflow),
    .o_underflow (o_underflow)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One product beat presented for exactly one clock edge.
  task automatic beat(input logic [21:0] s, input logic [21:0] c, input int e,
                      input logic sg, input logic ex, input logic lst);
    @(negedge CLK);
    i_valid     = 1'b1;
    i_sum       = s;
    i_carry     = c;
    i_exponent  = 6'(e);
    i_sign      = sg;
    i_exception = ex;
    i_last      = lst;
    @(posedge CLK);
    #1;
    i_valid     = 1'b0;
    i_exception = 1'b0;
    i_last      = 1'b0;
  endtask

  task automatic one(input logic sg, input logic lst);
    beat(22'h100000, 22'h0, 0, sg, 1'b0, lst);
  endtask

  // Waits (bounded) for the result, checks latency/value/flags, then consumes it.
  task automatic expect_res(input string tag, input logic [15:0] er,
                            input logic eo, input logic eu);
    int n;
    n = 1;
    @(negedge CLK);
    while (!o_valid && n < 20) begin
      @(negedge CLK);
      n++;
    end
    chk({tag, "_lat"}, n, 3);
    chk(tag, o_result, er);
    chk({tag, "_ovf"}, o_overflow, eo);
    chk({tag, "_unf"}, o_underflow, eu);
    o_ready = 1'b1;
    @(posedge CLK);
    #1;
    o_ready = 1'b0;
  endtask

  initial begin
    int n;
    RST = 1'b1; o_ready = 1'b0; i_valid = 1'b0; i_sum = '0; i_carry = '0;
    i_exponent = '0; i_sign = 1'b0; i_exception = 1'b0; i_last = 1'b0;
    #2 RST = 1'b0;
    repeat (3) @(negedge CLK);
    chk("rst_iready", i_ready, 1);
    chk("rst_ovalid", o_valid, 0);
    chk("rst_result", o_result, 16'h0000);
    chk("rst_ovf", o_overflow, 0);
    chk("rst_unf", o_underflow, 0);
    RST = 1'b1;

    beat(22'h0FFFFF, 22'h000001, 0, 1'b0, 1'b0, 1'b1);
    expect_res("one", 16'h3C00, 1'b0, 1'b0);

    one(1'b0, 1'b0); one(1'b1, 1'b1);
    expect_res("cancel", 16'h0000, 1'b0, 1'b0);

    one(1'b0, 1'b0); beat(22'h100000, 22'h0, -11, 1'b0, 1'b0, 1'b1);
    expect_res("tie_even", 16'h3C00, 1'b0, 1'b0);

    one(1'b0, 1'b0); beat(22'h100000, 22'h0, -11, 1'b0, 1'b0, 1'b0);
    beat(22'h100000, 22'h0, -20, 1'b0, 1'b0, 1'b1);
    expect_res("tie_sticky", 16'h3C01, 1'b0, 1'b0);

    beat(22'h100000, 22'h0, 30, 1'b0, 1'b0, 1'b1);
    expect_res("ovf", 16'h7C00, 1'b1, 1'b0);

    beat(22'h100000, 22'h0, -24, 1'b0, 1'b0, 1'b1);
    expect_res("min_sub", 16'h0001, 1'b0, 1'b0);

    beat(22'h100000, 22'h0, -26, 1'b0, 1'b0, 1'b1);
    expect_res("unf", 16'h0000, 1'b0, 1'b1);

    beat(22'h0C0000, 22'h0C0000, 0, 1'b1, 1'b0, 1'b1);
    expect_res("neg", 16'hBE00, 1'b0, 1'b0);

    // (2^11-1)*2^-25 is a tie just below 2^-14 and rounds up to the smallest normal
    beat(22'h0007FF, 22'h0, -5, 1'b0, 1'b0, 1'b1);
    expect_res("sub_to_norm", 16'h0400, 1'b0, 1'b0);

    beat(22'h000FFF, 22'h0, 9, 1'b0, 1'b0, 1'b1);
    expect_res("carry_out", 16'h4000, 1'b0, 1'b0);

    // 65520 is the tie above the largest finite value
    beat(22'h000FFF, 22'h0, 24, 1'b0, 1'b0, 1'b1);
    expect_res("max_to_inf", 16'h7C00, 1'b1, 1'b0);

    beat(22'h3FFFFF, 22'h100001, 0, 1'b0, 1'b0, 1'b1);
    expect_res("wrap_sum", 16'h3C00, 1'b0, 1'b0);

    one(1'b0, 1'b0); beat(22'h100000, 22'h0, 0, 1'b0, 1'b1, 1'b0); one(1'b0, 1'b1);
    expect_res("nan", 16'h7E00, 1'b0, 1'b0);
    one(1'b0, 1'b1);
    expect_res("nan_clear", 16'h3C00, 1'b0, 1'b0);

    beat(22'h100000, 22'h0, 31, 1'b0, 1'b0, 1'b1);
    expect_res("exp_range", 16'h7E00, 1'b0, 1'b0);

    // Downstream stall with an offered beat that must be ignored
    one(1'b0, 1'b1);
    n = 1;
    @(negedge CLK);
    while (!o_valid && n < 20) begin
      @(negedge CLK);
      n++;
    end
    chk("stall_lat", n, 3);
    i_valid = 1'b1; i_sum = 22'h100000; i_carry = '0; i_exponent = '0;
    i_sign = 1'b0; i_last = 1'b1;
    for (int k = 0; k < 5; k++) begin
      chk("stall_result", o_result, 16'h3C00);
      chk("stall_iready", i_ready, 0);
      chk("stall_ovalid", o_valid, 1);
      @(negedge CLK);
    end
    i_valid = 1'b0; i_last = 1'b0;
    o_ready = 1'b1;
    @(posedge CLK);
    #1;
    o_ready = 1'b0;
    one(1'b0, 1'b1);
    expect_res("after_stall", 16'h3C00, 1'b0, 1'b0);

    // Asynchronous reset mid-accumulation discards the partial sum
    one(1'b0, 1'b0); one(1'b0, 1'b0);
    @(negedge CLK);
    RST = 1'b0;
    #1;
    chk("midrst_ovalid", o_valid, 0);
    chk("midrst_iready", i_ready, 1);
    @(negedge CLK);
    RST = 1'b1;
    one(1'b0, 1'b1);
    expect_res("post_reset", 16'h3C00, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/kulisch_acc_fp16.md
# kulisch_acc_fp16

Consumer side of the fp16 Booth multiplier's redundant product interface. It accepts a stream of products, each given as a sum/carry mantissa pair plus an unbiased exponent and a sign, and accumulates them exactly in a wide Kulisch fixed-point register. On the last product of a dot product it normalizes, rounds to nearest-even and emits one IEEE-754 binary16 result under a valid/ready handshake. It sits after the multiplier array in the TensorCore accumulation path.

## Interface
- EWIDTH, 5: fp16 exponent width.
- MWIDTH, 10: fp16 fraction width.
- BIAS, 15: fp16 exponent bias.
- GUARD, 8: carry-guard bits; supports up to 2^GUARD products per dot product without wrap.
- CLK  in  1  clock, rising edge.
- RST  in  1  reset, asynchronous, active-low.
- i_valid  in  1  product beat valid.
- i_ready  out  1  accumulator can accept a beat.
- i_sum  in  2*MWIDTH+2  redundant mantissa, sum word.
- i_carry  in  2*MWIDTH+2  redundant mantissa, carry word.
- i_exponent  in  EWIDTH+1  signed unbiased product exponent, range -28..+30.
- i_sign  in  1  product sign.
- i_exception  in  1  the product is NaN or Inf.
- i_last  in  1  final beat of the dot product.
- o_valid  out  1  result valid.
- o_ready  in  1  downstream accepts the result.
- o_result  out  DWIDTH=16  fp16 result.
- o_overflow  out  1  result saturated to ±Inf.
- o_underflow  out  1  nonzero sum rounded to ±0.

## Operation
- Mantissa: M = (i_sum + i_carry) mod 2^22. Value = M·2^(i_exponent-20).
- Accumulator width: ACC_W = 81+GUARD, two's complement. LSB weight is 2^-48.
- Alignment: shift M left by sh = i_exponent+28, where 0 ≤ sh ≤ 58. An exponent outside -28..+30 is treated as i_exception.
- States:
  - ACC: i_ready=1.
  - DRAIN: pipeline empty after last; i_ready=0.
  - NORM: i_ready=0.
  - OUT: o_valid=1, i_ready=0.
- Transitions:
  - ACC→DRAIN on an accepted beat with i_last.
  - DRAIN→NORM after one cycle.
  - NORM→OUT after one cycle.
  - OUT→ACC on o_valid&&o_ready. The accumulator and flags clear in the same edge.
- Pipeline:
  - S1 registers the aligned, sign-applied operand and valid.
  - S2 adds S1 into the accumulator.
  - A beat accepted at cycle t affects the accumulator at t+2.
- Sticky NaN flag: set by any accepted beat with i_exception. If set, the result is 0x7E00 and no flags assert.
- Normalize/round (NORM, registered into o_result):
  - Sign = accumulator MSB. Magnitude = |acc|.
  - Leading-one position p gives exponent E = p-48.
  - E ≥ -14: normal. 10-bit fraction; guard/round/sticky taken from the bits below; RNE. A mantissa carry-out increments E.
  - E > 15 after rounding: ±Inf (0x7C00 | sign<<15) with o_overflow=1.
  - E < -14: subnormal. Fraction = magnitude at 2^-24 resolution, RNE. Rounding up to 2^-14 yields the smallest normal.
  - Nonzero magnitude that rounds to 0: ±0 with o_underflow=1.
  - Exact zero: 0x0000, positive sign.
- o_result/o_overflow/o_underflow are held stable while o_valid && !o_ready.
- Accumulator wrap beyond the GUARD bits is undefined; the caller limits the beat count.

## Timing
- Reset values:
  - State ACC, so i_ready=1.
  - o_valid=0, o_result=0x0000, o_overflow=0, o_underflow=0.
  - Accumulator, S1 and NaN flag all 0.
- Latency: last beat accepted at cycle t gives o_valid high at t+3.
- Throughput: one beat per cycle in ACC.
- Dot-product period: N+3 cycles, plus downstream stall cycles.
- i_valid while i_ready=0 is ignored and not buffered; the upstream holds the beat.
- Reset mid-operation: all state is discarded immediately (asynchronous). No partial result is emitted.
- A single-beat dot product (i_last on the first beat) is legal.

## Structure
- Package kulisch_pkg holds:
  - EWIDTH, MWIDTH, BIAS.
  - EXP_MIN=-28, EXP_MAX=30, FRAC_LSB=48, ACC_W.
  - State enum {ACC, DRAIN, NORM, OUT}.
  - Constants FP16_QNAN=16'h7E00, FP16_INF=16'h7C00.
- Sub-module kulisch_fp16_round: combinational LZC, normalize, RNE and the overflow/underflow flags. It takes the accumulator value and is instantiated once in the NORM stage.

## Test plan
- 1.0·1.0, single beat: sum=0x0FFFFF, carry=0x000001, exp=0, sign=0, last → o_result=0x3C00 at t+3, no flags.
- Beats +1.0 then -1.0 (exp=0, M=0x100000) → 0x0000, o_underflow=0.
- Rounding:
  - Beats 1.0 and 2^-11 (exp=-11, M=0x100000) → tie, rounds to even, 0x3C00.
  - Adding a third beat of 2^-20 → 0x3C01.
- Overflow and underflow:
  - exp=30, M=0x100000 → 0x7C00, o_overflow=1.
  - exp=-24 → 0x0001.
  - exp=-26 → 0x0000 with o_underflow=1.
- Exception: one beat with i_exception among three beats → 0x7E00. The next dot product (1.0) → 0x3C00, proving the flag clears.
- Handshake: hold o_ready=0 for 5 cycles → o_result stable and i_ready=0 throughout. Assert RST low mid-accumulation → o_valid=0 and i_ready=1 immediately; the next dot product is correct.
